// File: rtl/viterbi_channel_inj.sv
// Channel model between convolutional encoder and Viterbi decoder: XORs an LFSR-driven error mask into each symbol.
// Latency 1 cycle; no backpressure, state and counters freeze while enc_valid_i is low.
module viterbi_channel_inj #(
    parameter int          N         = 3,
    parameter int          WINDOW    = 256,
    parameter int          BURST_LEN = 4,
    parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enc_valid_i,
    input  logic [1:0]  enc_sym_i,
    input  logic        inj_en_i,
    input  logic [1:0]  mode_i,
    output logic        dec_valid_o,
    output logic [1:0]  dec_sym_o,
    output logic [1:0]  err_mask_o,
    output logic [15:0] sym_ct_o,
    output logic [15:0] inj_ct_o,
    output logic [15:0] bad_bit_ct_o,
    output logic        window_done_o
);

    localparam logic [31:0] SEED = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
    localparam logic [31:0] TAPS = 32'h8020_0003;
    localparam logic [15:0] WIN  = 16'(WINDOW);
    localparam int          RW   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [1:0] {ARMED, BURST, DONE} state_t;

    state_t        state, nxt_state;
    logic [31:0]   lfsr, nxt_lfsr;
    logic [RW-1:0] rem, nxt_rem;
    logic [15:0]   sym_ct, inj_ct, bad_ct;
    logic [1:0]    mask;
    logic          trig, allow, last_win;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {15'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign trig     = &lfsr[N-1:0];
    assign allow    = inj_en_i & (sym_ct < WIN) & (mode_i != 2'b00);
    assign last_win = (sym_ct == WIN - 16'd1);
    assign nxt_lfsr = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'h0);

    always_comb begin
        mask      = 2'b00;
        nxt_state = state;
        nxt_rem   = rem;
        case (state)
            ARMED: begin
                if (trig && allow) begin
                    case (mode_i)
                        2'b01: mask = 2'b01;
                        2'b10: mask = lfsr[N] ? 2'b10 : 2'b01;
                        2'b11: begin
                            mask = 2'b01;
                            if (BURST_LEN > 1) begin
                                nxt_state = BURST;
                                nxt_rem   = RW'(BURST_LEN - 1);
                            end
                        end
                        default: mask = 2'b00;
                    endcase
                end
            end
            BURST: begin
                // Any loss of permission (or leaving burst mode) kills the burst for good.
                if (allow && mode_i == 2'b11) begin
                    mask    = 2'b01;
                    nxt_rem = rem - RW'(1);
                    if (rem == RW'(1)) nxt_state = ARMED;
                end else begin
                    nxt_rem   = '0;
                    nxt_state = ARMED;
                end
            end
            default: mask = 2'b00;
        endcase
        if (last_win) begin
            nxt_state = DONE;
            nxt_rem   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ARMED;
            lfsr          <= SEED;
            rem           <= '0;
            sym_ct        <= '0;
            inj_ct        <= '0;
            bad_ct        <= '0;
            dec_valid_o   <= 1'b0;
            dec_sym_o     <= 2'b00;
            err_mask_o    <= 2'b00;
            window_done_o <= 1'b0;
        end else begin
            dec_valid_o <= enc_valid_i;
            if (enc_valid_i) begin
                dec_sym_o     <= enc_sym_i ^ mask;
                err_mask_o    <= mask;
                lfsr          <= nxt_lfsr;
                state         <= nxt_state;
                rem           <= nxt_rem;
                sym_ct        <= sat_add(sym_ct, 2'd1);
                inj_ct        <= sat_add(inj_ct, {1'b0, |mask});
                bad_ct        <= sat_add(bad_ct, {1'b0, mask[1]} + {1'b0, mask[0]});
                window_done_o <= window_done_o | last_win;
            end else begin
                err_mask_o <= 2'b00;
            end
        end
    end

    assign sym_ct_o     = sym_ct;
    assign inj_ct_o     = inj_ct;
    assign bad_bit_ct_o = bad_ct;

endmodule

// File: tb/tb_viterbi_channel_inj.sv
// Bench for viterbi_channel_inj: directed scenarios plus random traffic against a symbol-level reference model.
module tb_viterbi_channel_inj;

    localparam int          N         = 3;
    localparam int          WINDOW    = 256;
    localparam int          BURST_LEN = 4;
    localparam logic [31:0] SEED      = 32'h7;
    localparam logic [31:0] TAPS      = 32'h8020_0003;
    localparam logic [31:0] TRIGM     = (32'h1 << N) - 32'h1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enc_valid_i = 1'b0;
    logic [1:0]  enc_sym_i = 2'b00;
    logic        inj_en_i = 1'b0;
    logic [1:0]  mode_i = 2'b00;
    logic        dec_valid_o;
    logic [1:0]  dec_sym_o;
    logic [1:0]  err_mask_o;
    logic [15:0] sym_ct_o;
    logic [15:0] inj_ct_o;
    logic [15:0] bad_bit_ct_o;
    logic        window_done_o;

    viterbi_channel_inj #(
        .N(N), .WINDOW(WINDOW), .BURST_LEN(BURST_LEN), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst),
        .enc_valid_i(enc_valid_i), .enc_sym_i(enc_sym_i),
        .inj_en_i(inj_en_i), .mode_i(mode_i),
        .dec_valid_o(dec_valid_o), .dec_sym_o(dec_sym_o), .err_mask_o(err_mask_o),
        .sym_ct_o(sym_ct_o), .inj_ct_o(inj_ct_o), .bad_bit_ct_o(bad_bit_ct_o),
        .window_done_o(window_done_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: symbol index, burst symbols still owed, plain integer counters.
    logic [31:0] m_lfsr;
    int          m_owed, m_sym, m_inj, m_bad;
    logic        e_valid;
    logic [1:0]  e_sym, e_mask;

    function automatic int sat(input int x);
        return (x > 65535) ? 65535 : x;
    endfunction

    task automatic model_reset();
        m_lfsr = SEED; m_owed = 0; m_sym = 0; m_inj = 0; m_bad = 0;
        e_valid = 1'b0; e_sym = 2'b00; e_mask = 2'b00;
    endtask

    task automatic model_step(input logic v, input logic [1:0] s, input logic en, input logic [1:0] m);
        logic [1:0] mk;
        logic trig, allow;
        mk = 2'b00;
        e_valid = v;
        if (!v) begin
            e_mask = 2'b00;
            return;
        end
        trig  = (m_lfsr & TRIGM) == TRIGM;
        allow = en && (m_sym < WINDOW) && (m != 2'b00);
        if (m_sym < WINDOW) begin
            if (m_owed > 0) begin
                if (allow && m == 2'b11) begin
                    mk = 2'b01;
                    m_owed--;
                end else begin
                    m_owed = 0;
                end
            end else if (trig && allow) begin
                mk = (m == 2'b10 && m_lfsr[N]) ? 2'b10 : 2'b01;
                if (m == 2'b11) m_owed = BURST_LEN - 1;
            end
        end
        if (m_sym + 1 >= WINDOW) m_owed = 0;
        e_sym  = s ^ mk;
        e_mask = mk;
        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? TAPS : 32'h0);
        m_sym  = sat(m_sym + 1);
        m_inj  = sat(m_inj + ((mk != 2'b00) ? 1 : 0));
        m_bad  = sat(m_bad + $countones(mk));
    endtask

    task automatic step(input logic v, input logic [1:0] s, input logic en, input logic [1:0] m);
        @(negedge clk);
        enc_valid_i = v; enc_sym_i = s; inj_en_i = en; mode_i = m;
        model_step(v, s, en, m);
        @(posedge clk);
        #1;
        chk("dec_valid", {31'b0, dec_valid_o}, {31'b0, e_valid});
        chk("dec_sym", {30'b0, dec_sym_o}, {30'b0, e_sym});
        chk("err_mask", {30'b0, err_mask_o}, {30'b0, e_mask});
        chk("sym_ct", {16'b0, sym_ct_o}, m_sym);
        chk("inj_ct", {16'b0, inj_ct_o}, m_inj);
        chk("bad_bit_ct", {16'b0, bad_bit_ct_o}, m_bad);
        chk("window_done", {31'b0, window_done_o}, (m_sym >= WINDOW) ? 32'd1 : 32'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, {31'b0, dec_valid_o}, 32'd0);
        chk({tag, "_sym"}, {30'b0, dec_sym_o}, 32'd0);
        chk({tag, "_mask"}, {30'b0, err_mask_o}, 32'd0);
        chk({tag, "_sym_ct"}, {16'b0, sym_ct_o}, 32'd0);
        chk({tag, "_inj_ct"}, {16'b0, inj_ct_o}, 32'd0);
        chk({tag, "_bad_ct"}, {16'b0, bad_bit_ct_o}, 32'd0);
        chk({tag, "_done"}, {31'b0, window_done_o}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        enc_valid_i = 1'b0;
        #2 rst = 1'b0;
        #1 check_zero("reset");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [1:0] q_sym[$];
    logic [1:0] q_mask[$];
    logic [1:0] cur_mode;
    logic       cur_en;

    initial begin
        model_reset();
        #3 check_zero("por");
        @(negedge clk);
        rst = 1'b1;

        // Clean passthrough across the window boundary.
        for (int i = 0; i < 300; i++) step(1'b1, 2'($urandom), 1'b1, 2'b00);
        chk("t1_sym_ct", {16'b0, sym_ct_o}, 32'd300);
        chk("t1_inj_ct", {16'b0, inj_ct_o}, 32'd0);
        chk("t1_done", {31'b0, window_done_o}, 32'd1);

        // Seed 7 triggers on the very first symbol.
        do_reset();
        step(1'b1, 2'b10, 1'b1, 2'b01);
        chk("t2_sym", {30'b0, dec_sym_o}, 32'd3);
        chk("t2_mask", {30'b0, err_mask_o}, 32'd1);
        chk("t2_bad", {16'b0, bad_bit_ct_o}, 32'd1);
        step(1'b1, 2'b10, 1'b1, 2'b01);
        chk("t2_clean", {30'b0, dec_sym_o}, 32'd2);

        // Valid gaps freeze the LFSR.
        do_reset();
        step(1'b1, 2'b01, 1'b1, 2'b01);
        step(1'b0, 2'b11, 1'b1, 2'b01);
        step(1'b0, 2'b11, 1'b1, 2'b01);
        step(1'b1, 2'b01, 1'b1, 2'b01);
        for (int i = 0; i < 20; i++) step(1'($urandom_range(0, 1)), 2'($urandom), 1'b1, 2'b10);

        // Full burst from the first trigger.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 2'b00, 1'b1, 2'b11);
            if (i < 4) chk("t4_burst_mask", {30'b0, err_mask_o}, 32'd1);
        end
        chk("t4_inj_ge4", {31'b0, inj_ct_o >= 16'd4}, 32'd1);

        // Burst truncated when injection is disabled.
        do_reset();
        step(1'b1, 2'b00, 1'b1, 2'b11);
        step(1'b1, 2'b00, 1'b1, 2'b11);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'b00, 1'b0, 2'b11);
            chk("t5_abort_mask", {30'b0, err_mask_o}, 32'd0);
        end
        chk("t5_inj_ct", {16'b0, inj_ct_o}, 32'd2);
        step(1'b1, 2'b00, 1'b1, 2'b11);

        // Reset during an active burst, then replay must reproduce the masks.
        do_reset();
        for (int i = 0; i < 250 && (i < 100 || m_owed == 0); i++) begin
            q_sym.push_back(2'($urandom));
            step(1'b1, q_sym[$], 1'b1, 2'b11);
            q_mask.push_back(err_mask_o);
        end
        chk("t6_burst_active", {31'b0, m_owed > 0}, 32'd1);
        do_reset();
        foreach (q_sym[i]) begin
            step(1'b1, q_sym[i], 1'b1, 2'b11);
            chk("t6_replay_mask", {30'b0, err_mask_o}, {30'b0, q_mask[i]});
        end

        // Random traffic with mode/enable changes.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            cur_mode = 2'($urandom);
            cur_en   = 1'b1;
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 15) == 0) cur_mode = 2'($urandom);
                if ($urandom_range(0, 15) == 0) cur_en = ~cur_en;
                step(($urandom_range(0, 3) != 0), 2'($urandom), cur_en, cur_mode);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/viterbi_channel_inj.md
Name: viterbi_channel_inj

Overview:
Synthesizable channel model between the convolutional encoder and the Viterbi decoder. Registers each 2-bit encoder symbol and XORs in a pseudo-random error mask from a seeded LFSR. Injection is limited to a programmable symbol window. Keeps injected-symbol and flipped-bit counters so decoder BER runs are reproducible and self-checking.

Parameters:
N, 3, trigger rate: inject when lfsr[N-1:0] is all ones (1 in 2**N symbols); 1 <= N <= 8
WINDOW, 256, number of valid symbols after reset during which injection is allowed
BURST_LEN, 4, symbols corrupted per trigger in burst mode (>=1)
LFSR_SEED, 32'h0000_0001, LFSR reset value; 0 is forced to 1

Ports:
clk  in  1  clock
rst  in  1  async active-low reset
enc_valid_i  in  1  encoder symbol valid
enc_sym_i  in  2  encoder symbol {g1,g0}
inj_en_i  in  1  injection enable (sampled with each valid symbol)
mode_i  in  2  00 off, 01 random bit0, 10 random single bit, 11 burst on bit0
dec_valid_o  out  1  symbol valid to decoder
dec_sym_o  out  2  possibly-corrupted symbol to decoder
err_mask_o  out  2  mask applied to current dec_sym_o
sym_ct_o  out  16  valid symbols accepted, saturating
inj_ct_o  out  16  symbols with nonzero mask, saturating
bad_bit_ct_o  out  16  total flipped bits, saturating
window_done_o  out  1  high once WINDOW symbols accepted

Behaviour:
- Reset (rst=0, async): all outputs 0, lfsr=LFSR_SEED (or 1 if seed is 0), FSM=ARMED, burst counter 0.
- Latency: exactly 1 cycle. dec_valid_o(t+1)=enc_valid_i(t); dec_sym_o(t+1)=enc_sym_i(t)^mask(t); err_mask_o(t+1)=mask(t).
- enc_valid_i=0: dec_valid_o=0 next cycle, dec_sym_o holds, err_mask_o=0. LFSR, counters, and FSM are frozen.
- LFSR advances only on valid symbols: next = {1'b0,lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 0).
- Trigger uses the pre-advance value: trig = (lfsr[N-1:0] == all ones).
- allow = inj_en_i & (sym_ct < WINDOW) & (mode_i != 00).
- FSM states and mask per valid symbol:
  - ARMED:
    - mode 01: mask = trig&allow ? 01 : 00.
    - mode 10: mask = trig&allow ? (lfsr[N] ? 10 : 01) : 00.
    - mode 11: if trig&allow, mask = 01. If BURST_LEN>1, go to BURST with remaining = BURST_LEN-1.
  - BURST: mask = 01, remaining decrements, triggers ignored. Go to ARMED when remaining reaches 0 on this symbol. If allow=0 (inj_en_i drops, mode changes, or window ends), mask = 00 and go to ARMED immediately; the burst is truncated and not resumed.
  - DONE: entered on the valid symbol that makes sym_ct = WINDOW. Mask always 00. Left only by reset.
- window_done_o: 1 from the cycle after the WINDOW-th valid symbol until reset.
- Counters on each valid symbol, all saturating at 16'hFFFF:
  - sym_ct += 1
  - inj_ct += (mask != 0)
  - bad_bit_ct += popcount(mask)
- inj_en_i=0 or mode 00: clean passthrough; LFSR and sym_ct still advance, so the error pattern stays seed-aligned to symbol index.
- mode_i changes mid-run take effect on the next valid symbol.

Test Plan:
1. mode=00, inj_en=1, 300 valid symbols -> dec_sym_o equals enc_sym_i delayed 1 cycle; err_mask_o=0 always; inj_ct=bad_bit_ct=0; sym_ct=300; window_done_o=1 after symbol 256.
2. LFSR_SEED=32'h7, N=3, mode=01, one valid symbol 2'b10 -> next cycle dec_sym_o=2'b11, err_mask_o=01, inj_ct=1, bad_bit_ct=1. Second valid symbol (lfsr=32'h8020_0000, no trigger) passes clean.
3. Valid gaps: enc_valid_i pattern 1,0,0,1 -> dec_valid_o mirrors it 1 cycle later. The LFSR value after 2 valid symbols matches a gap-free run (compare against a reference model).
4. LFSR_SEED=32'h7, mode=11, BURST_LEN=4, 6 valid symbols 2'b00 -> masks 01,01,01,01, then trigger-dependent. inj_ct>=4, bad_bit_ct>=4.
5. Burst abort: same as 4 but inj_en_i drops before symbol 3 -> symbols 3 onward carry mask 00, FSM=ARMED, inj_ct=2.
6. Reset mid-run after 100 symbols with burst active -> all outputs 0 immediately. The next run reproduces the same mask sequence from symbol 0.
